apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

Parametrised APB memory slave: a single-select APB target fronting a DEPTH-word register file with configurable data/address width, programmable wait states, byte write strobes and an optional error response. It sits behind the APB bridge as a peripheral-side slave and supersedes the fixed 8-bit, zero-wait single-slave memory.

## Interface
Parameters:
- ADDR_W, 8: width of paddr (byte address).
- DATA_W, 32: width of pwdata/prdata. Must be 8, 16 or 32.
- DEPTH, 16: number of DATA_W-bit words. Must be ≥ 2 and fit in the address space.
- WAIT_STATES, 0: number of wait cycles (PREADY low) inserted in ACCESS, 0..15.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESET  in  1  reset, asynchronous and active-high.
- PSEL1  in  1  slave select.
- PENABLE  in  1  access phase qualifier.
- PWRITE  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes; pstrb[i] enables pwdata[8i+7:8i].
- prdata  out  DATA_W  read data, registered.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- Word index = paddr >> log2(DATA_W/8); low byte-offset bits are ignored. Index ≥ DEPTH is out of range.
- FSM states:
  - IDLE: PREADY=0. If PSEL1=1 and PENABLE=0, go to SETUP. PENABLE=1 without a preceding SETUP is ignored.
  - SETUP: load the wait counter with WAIT_STATES and capture the read word into prdata. Go to ACCESS.
  - ACCESS: PREADY = (counter==0). While counter≠0, decrement it each cycle and keep re-capturing prdata.
    - On the completing cycle (PREADY=1 and PENABLE=1), a write commits only the strobed bytes.
    - Then go to SETUP if PSEL1=1 and PENABLE=0 next, else to IDLE.
    - If PSEL1 drops before completion, abort to IDLE; no write occurs.
- A read transfer returns the word as it was before any write in the same transfer. Write-only transfers leave prdata unchanged.
- Memory contents are not initialised by reset and survive PRESET.
- pstrb=0 on a write completes normally with no memory change.

## Timing
- Reset values: PREADY=0, PSLVERR=0, prdata=0, FSM=IDLE, wait counter=0. Asserting PRESET mid-transfer forces these values immediately (asynchronously); a pending write is discarded.
- Transfer length is 2 + WAIT_STATES cycles, SETUP included. With WAIT_STATES=0, PREADY is high in the first ACCESS cycle.
- prdata is stable for the whole cycle in which PREADY=1 and holds its value until the next read's SETUP capture.
- Back-to-back transfers: a new SETUP may follow the completing ACCESS cycle directly, with no IDLE cycle in between.
- PSLVERR is low whenever PREADY is low.

## Configuration
- APB_SLAVE_PSLVERR_EN defined:
  - An out-of-range transfer completes with PREADY=1 and PSLVERR=1 after the normal wait states.
  - Writes are suppressed and reads return prdata=0.
- APB_SLAVE_PSLVERR_EN undefined:
  - PSLVERR is tied to 0.
  - Out-of-range writes are silently dropped and reads return 0.
  - Timing is otherwise identical.

## Test plan
Settings: DATA_W=32, DEPTH=16, WAIT_STATES=2 unless noted.
- Reset: assert PRESET mid-ACCESS of a write to paddr=0x04 → PREADY, PSLVERR and prdata go to 0 immediately. A later read of 0x04 returns its prior value.
- Write then read: write 0xDEADBEEF to 0x08 with pstrb=0xF, then read 0x08 → PREADY high exactly 3 cycles after SETUP, prdata=0xDEADBEEF.
- Partial write: write 0x11223344 to 0x08 with pstrb=0x5 over 0xDEADBEEF → read returns 0xDE22BE44.
- Back-to-back, WAIT_STATES=0: write 0x0C then immediately read 0x0C → each transfer takes 2 cycles, no IDLE gap, read returns the written data.
- Out of range: write then read paddr=0x40.
  - With APB_SLAVE_PSLVERR_EN defined → PSLVERR=1 on the PREADY cycle and prdata=0.
  - With it undefined → PSLVERR=0 and prdata=0.
  - In both builds, word 0 is unchanged.
- Abort: drop PSEL1 after one wait cycle of a write to 0x10 → FSM returns to IDLE, no PREADY pulse, memory unchanged.

Source files
------------

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and the memory slave.
// Clock and reset stay outside the bundle as plain ports.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  PSEL1;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL1, PENABLE, PWRITE, paddr, pwdata, pstrb,
    input  prdata, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL1, PENABLE, PWRITE, paddr, pwdata, pstrb,
    output prdata, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB memory slave: DEPTH-word register file with wait states and byte strobes.
// Define APB_SLAVE_PSLVERR_EN to flag out-of-range transfers with PSLVERR.
module apb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_slave_mem_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d, phase;
  logic [3:0]          waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   wordAddr;
  logic [DATA_W-1:0]   readWord;
  logic                inRange;
  logic                ready;
  logic                commit;

  assign wordAddr = bus.paddr >> OFFS;
  assign inRange  = 32'(wordAddr) < 32'(DEPTH);
  assign readWord = inRange ? mem_q[wordAddr[IDX_W-1:0]] : '0;

  // The setup phase is recognised in the cycle the master presents it, so the
  // state register itself only ever holds IDLE or ACCESS.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && bus.PSEL1 && !bus.PENABLE) begin
      phase = SETUP;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    prdata_d  = prdata_q;
    ready     = 1'b0;
    commit    = 1'b0;
    case (phase)
      IDLE: begin
        state_d = IDLE;
      end
      SETUP: begin
        waitCnt_d = 4'(WAIT_STATES);
        if (!bus.PWRITE) begin
          prdata_d = readWord;
        end
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!bus.PSEL1) begin
          state_d = IDLE;
        end else if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
          if (!bus.PWRITE) begin
            prdata_d = readWord;
          end
        end else begin
          ready = 1'b1;
          if (bus.PENABLE) begin
            commit  = bus.PWRITE && inRange;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage is deliberately left out of reset so contents survive PRESET.
  always_ff @(posedge PCLK) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.pstrb[b]) begin
          mem_q[wordAddr[IDX_W-1:0]][8*b +: 8] <= bus.pwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.PREADY = ready;
  assign bus.prdata = prdata_q;
`ifdef APB_SLAVE_PSLVERR_EN
  assign bus.PSLVERR = ready && !inRange;
`else
  assign bus.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: a 2-wait-state instance for most tests
// and a zero-wait instance for back-to-back transfers.
module tb_apb_slave_mem;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expData;
    bit          oor;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        selSlow = 1'b0;
  logic        selFast = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  int          cycleCount = 0;
  int          checksTotal = 0;
  int          checksPassed = 0;
  exp_t        sbq[$];
  vec_t        vecs[19];

  apb_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifSlow ();
  apb_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifFast ();

  assign ifSlow.PSEL1   = selSlow;
  assign ifSlow.PENABLE = penable;
  assign ifSlow.PWRITE  = pwrite;
  assign ifSlow.paddr   = paddr;
  assign ifSlow.pwdata  = pwdata;
  assign ifSlow.pstrb   = pstrb;
  assign ifFast.PSEL1   = selFast;
  assign ifFast.PENABLE = penable;
  assign ifFast.PWRITE  = pwrite;
  assign ifFast.paddr   = paddr;
  assign ifFast.pwdata  = pwdata;
  assign ifFast.pstrb   = pstrb;

  apb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16), .WAIT_STATES(2)) dutSlow (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (ifSlow)
  );

  apb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(16), .WAIT_STATES(0)) dutFast (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (ifFast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic getReady(bit fast);
    return fast ? ifFast.PREADY : ifSlow.PREADY;
  endfunction

  function automatic logic getErr(bit fast);
    return fast ? ifFast.PSLVERR : ifSlow.PSLVERR;
  endfunction

  function automatic logic [31:0] getData(bit fast);
    return fast ? ifFast.prdata : ifSlow.prdata;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end else begin
      checksPassed++;
    end
  endtask

  // Runs one complete transfer starting in the current cycle; the expected
  // result is queued at drive time and compared when PREADY appears.
  task automatic applyStimulus(input bit fast, input bit wr, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] expData, input bit oor, input string name);
    exp_t e;
    int   cyc;
    e.name   = name;
    e.data   = expData;
    e.err    = oor && ERR_EN;
    e.cycles = fast ? 1 : 3;
    sbq.push_back(e);
    selFast = fast;
    selSlow = !fast;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    while (!getReady(fast) && cyc < 40) begin
      checkOutput({name, " errLowWhileWait"}, 32'(getErr(fast)), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    e = sbq.pop_front();
    if (!getReady(fast)) begin
      checksTotal++;
      $display("[TB] FAIL %s timeout: PREADY never rose, expected after %0d cycles", e.name, e.cycles);
    end else begin
      checkOutput({e.name, " readyCycles"}, 32'(cyc), 32'(e.cycles));
      checkOutput({e.name, " prdata"}, getData(fast), e.data);
      checkOutput({e.name, " pslverr"}, 32'(getErr(fast)), 32'(e.err));
    end
    @(posedge clk); #1;
    selFast = 1'b0;
    selSlow = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    int t0;

    //            wr    addr   wdata         strb  expData       oor
    vecs[0]  = '{1'b1, 8'h00, 32'hA5A50000, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 8'h04, 32'h12345678, 4'hF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, 8'h10, 32'h55AA55AA, 4'hF, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[7]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h12345678, 1'b0};
    vecs[8]  = '{1'b1, 8'h0E, 32'hCAFEF00D, 4'hF, 32'h12345678, 1'b0};
    vecs[9]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 8'h3C, 32'h0F0F0F0F, 4'hF, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b0, 8'h3F, 32'h0,        4'h0, 32'h0F0F0F0F, 1'b0};
    vecs[12] = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 32'h0F0F0F0F, 1'b0};
    vecs[13] = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[14] = '{1'b1, 8'h40, 32'h99999999, 4'hF, 32'hDE22BE44, 1'b1};
    vecs[15] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h00000000, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'hA5A50000, 1'b0};
    vecs[17] = '{1'b1, 8'hFC, 32'h77777777, 4'hF, 32'hA5A50000, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 32'h0,        4'h0, 32'hA5A50000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset slow PREADY",  32'(ifSlow.PREADY),  32'd0);
    checkOutput("reset slow PSLVERR", 32'(ifSlow.PSLVERR), 32'd0);
    checkOutput("reset slow prdata",  ifSlow.prdata,       32'd0);
    checkOutput("reset fast PREADY",  32'(ifFast.PREADY),  32'd0);
    checkOutput("reset fast prdata",  ifFast.prdata,       32'd0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    vecs[i].expData, vecs[i].oor, $sformatf("vec%0d", i));
      if (i % 2 == 1) begin
        @(posedge clk); #1;
      end
    end

    // Reset lands in the cycle PREADY is high for a write to 0x04.
    selSlow = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h04; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("midReset PREADY before", 32'(ifSlow.PREADY), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midReset PREADY",  32'(ifSlow.PREADY),  32'd0);
    checkOutput("midReset PSLVERR", 32'(ifSlow.PSLVERR), 32'd0);
    checkOutput("midReset prdata",  ifSlow.prdata,       32'd0);
    selSlow = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postReset idle PREADY", 32'(ifSlow.PREADY), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, 32'h12345678, 1'b0, "postReset read04");

    // Back-to-back on the zero-wait instance: four cycles for two transfers.
    @(posedge clk); #1;
    t0 = cycleCount;
    applyStimulus(1'b1, 1'b1, 8'h0C, 32'h600DF00D, 4'hF, 32'h00000000, 1'b0, "b2b write0C");
    applyStimulus(1'b1, 1'b0, 8'h0C, 32'h0,        4'h0, 32'h600DF00D, 1'b0, "b2b read0C");
    checkOutput("b2b totalCycles", 32'(cycleCount - t0), 32'd4);

    // Abort: PSEL1 drops after one wait cycle of a write to 0x10.
    @(posedge clk); #1;
    selSlow = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h10; pwdata = 32'h00000000; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    checkOutput("abort wait PREADY", 32'(ifSlow.PREADY), 32'd0);
    @(posedge clk); #1;
    selSlow = 1'b0; penable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("abort noReady%0d", k), 32'(ifSlow.PREADY), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, "abort read10");

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
